// File: rtl/mult_pkg.sv
// mult_pkg
//   Shared definitions for the multiplier arbiter slice: operand and product
//   widths and the arbiter FSM state type.
package mult_pkg;

    localparam int unsigned OPW   = 32;
    localparam int unsigned PRODW = 64;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_HI,
        WAIT_LO,
        RESP
    } state_e;

endpackage

// File: rtl/mult_arbiter_rr.sv
// rr_arbiter
//   Combinational round-robin grant. Searches the request vector starting
//   at ptr + 1 (wrapping modulo N) and grants the first active requester.
// Ports:
//   req    in  N      request vector
//   ptr    in  IDX_W  index of the last granted requester
//   grant  out N      one-hot grant, zero when no request is active
module rr_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant
);

    always_comb begin
        logic             found;
        logic [IDX_W-1:0] idx;
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            idx = IDX_W'((32'(ptr) + i) % N);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// mult_arbiter
//   Shares one multiplier among N_REQ requesters. One operation is in flight
//   at a time: accept in IDLE, pulse mult_start in ISSUE, wait for the
//   multiplier busy handshake (rise then fall), then return the product to
//   the owning requester with a one-cycle resp_valid pulse.
//   Optional macro MULT_ARB_ZERO_SKIP_EN: a request with a zero operand
//   bypasses the multiplier and responds with 0 one cycle after accept.
// Ports:
//   clk, reset                 clock (rising edge), async active-high reset
//   req_valid / req_ready      per-requester request handshake (ready one-hot)
//   req_a / req_b              per-requester 32-bit operands
//   resp_valid                 per-requester one-cycle result pulse
//   resp_product               shared 64-bit result bus
//   mult_start, mult_a, mult_b request to the multiplier
//   mult_busy, mult_product    status and result from the multiplier
module mult_arbiter
    import mult_pkg::*;
#(
    parameter int unsigned N_REQ = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_REQ-1:0]            req_valid,
    output logic [N_REQ-1:0]            req_ready,
    input  logic [N_REQ-1:0][OPW-1:0]   req_a,
    input  logic [N_REQ-1:0][OPW-1:0]   req_b,
    output logic [N_REQ-1:0]            resp_valid,
    output logic [PRODW-1:0]            resp_product,
    output logic                        mult_start,
    output logic [OPW-1:0]              mult_a,
    output logic [OPW-1:0]              mult_b,
    input  logic                        mult_busy,
    input  logic [PRODW-1:0]            mult_product
);

    localparam int unsigned IDX_W = $clog2(N_REQ);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  gnt_q, gnt_d;
    logic [OPW-1:0]    a_q, a_d;
    logic [OPW-1:0]    b_q, b_d;
    logic [PRODW-1:0]  prod_q, prod_d;

    logic [N_REQ-1:0]  grant;
    logic [IDX_W-1:0]  grant_idx;

    rr_arbiter #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (grant)
    );

    always_comb begin
        grant_idx = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                grant_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gnt_d      = gnt_q;
        a_d        = a_q;
        b_d        = b_q;
        prod_d     = prod_q;
        req_ready  = '0;
        mult_start = 1'b0;
        resp_valid = '0;

        case (state_q)
            IDLE: begin
                req_ready = grant;
                if (|req_valid) begin
                    ptr_d = grant_idx;
                    gnt_d = grant_idx;
                    a_d   = req_a[grant_idx];
                    b_d   = req_b[grant_idx];
`ifdef MULT_ARB_ZERO_SKIP_EN
                    if (req_a[grant_idx] == '0 || req_b[grant_idx] == '0) begin
                        prod_d  = '0;
                        state_d = RESP;
                    end else begin
                        state_d = ISSUE;
                    end
`else
                    state_d = ISSUE;
`endif
                end
            end
            ISSUE: begin
                mult_start = 1'b1;
                state_d    = WAIT_HI;
            end
            WAIT_HI: begin
                if (mult_busy) begin
                    state_d = WAIT_LO;
                end
            end
            WAIT_LO: begin
                // Capture on the falling edge of busy so the product is on
                // the bus for the whole RESP cycle.
                if (!mult_busy) begin
                    prod_d  = mult_product;
                    state_d = RESP;
                end
            end
            RESP: begin
                resp_valid[gnt_q] = 1'b1;
                state_d           = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= IDX_W'(N_REQ - 1);
            gnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            prod_q  <= prod_d;
        end
    end

    assign mult_a       = a_q;
    assign mult_b       = b_q;
    assign resp_product = prod_q;

endmodule
